// File: rtl/crc8_framer.sv
// Frame sequencer around a byte-wide CRC-8 engine: clears the engine per frame,
// forwards payload bytes through one output register and appends the CRC byte.
module crc8_framer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [7:0]             m_data_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic                   crc_rst_o,
    output logic [7:0]             crc_data_o,
    output logic                   crc_valid_o,
    input  logic [7:0]             crc_i,
    output logic [COUNT_WIDTH-1:0] frames_o
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        PASS  = 2'd1,
        CRC   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;

    logic slot_free;
    logic in_xfer;

    assign slot_free   = !m_valid_q || m_ready_i;
    assign s_ready_o   = (state_q == PASS) && slot_free;
    assign in_xfer     = s_valid_i && s_ready_o;
    assign crc_valid_o = in_xfer;
    assign crc_rst_o   = (state_q == CLEAR);
    assign crc_data_o  = s_data_i;

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
    assign frames_o  = frames_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            frames_q  <= frames_d;
        end
    end

    // By default the output register drains; a stalled beat stays put. In CRC the
    // engine holds its result while crc_valid_o is low, so crc_i is read directly.
    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready_i;
        m_last_d  = m_last_q;
        frames_d  = frames_q;

        case (state_q)
            CLEAR: begin
                state_d = PASS;
            end
            PASS: begin
                if (in_xfer) begin
                    m_data_d  = s_data_i;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    if (s_last_i) begin
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                if (slot_free) begin
                    m_data_d  = crc_i;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    frames_d  = frames_q + COUNT_WIDTH'(1);
                    state_d   = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_crc8_framer.sv
// Bench for crc8_framer: behavioural CRC-8 engine (poly 0x07, init 0x00) on the
// engine port, and a frame-level reference model computing CRCs bit-serially.
module tb_crc8_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sData = 8'h00;
    logic       sValid = 1'b0;
    logic       sLast = 1'b0;
    logic       sReady;
    logic [7:0] mData;
    logic       mValid;
    logic       mLast;
    logic       mReady = 1'b1;
    logic       crcRst;
    logic [7:0] crcData;
    logic       crcValid;
    logic [15:0] framesWide;

    logic       sReadyN;
    logic [7:0] mDataN;
    logic       mValidN;
    logic       mLastN;
    logic       crcRstN;
    logic [7:0] crcDataN;
    logic       crcValidN;
    logic [1:0] framesNarrow;

    logic [7:0] engCrc = 8'h00;
    logic [7:0] engTable [256];

    int testsRun = 0;
    int testsFailed = 0;
    int expFrames = 0;
    int rstPulses = 0;
    logic [8:0] gotQ[$];

    always #5 clk = ~clk;

    crc8_framer dut (
        .clk_i(clk), .rst_i(rst),
        .s_data_i(sData), .s_valid_i(sValid), .s_last_i(sLast), .s_ready_o(sReady),
        .m_data_o(mData), .m_valid_o(mValid), .m_last_o(mLast), .m_ready_i(mReady),
        .crc_rst_o(crcRst), .crc_data_o(crcData), .crc_valid_o(crcValid),
        .crc_i(engCrc), .frames_o(framesWide)
    );

    // Same stimulus, narrow counter, to exercise the wrap.
    crc8_framer #(.COUNT_WIDTH(2)) dutWrap (
        .clk_i(clk), .rst_i(rst),
        .s_data_i(sData), .s_valid_i(sValid), .s_last_i(sLast), .s_ready_o(sReadyN),
        .m_data_o(mDataN), .m_valid_o(mValidN), .m_last_o(mLastN), .m_ready_i(mReady),
        .crc_rst_o(crcRstN), .crc_data_o(crcDataN), .crc_valid_o(crcValidN),
        .crc_i(engCrc), .frames_o(framesNarrow)
    );

    function automatic logic [7:0] tableEntry(input int idx);
        logic [7:0] c;
        c = 8'(idx);
        repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) engTable[i] = tableEntry(i);
    end

    // Table-driven engine: result is registered, valid the cycle after the strobe.
    always @(posedge clk) begin
        if (crcRst) engCrc <= 8'h00;
        else if (crcValid) engCrc <= engTable[engCrc ^ crcData];
    end

    // Reference: CRC as polynomial division of the frame's bit stream, MSB first.
    function automatic logic [7:0] refCrc(input logic [7:0] q[$]);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic applyReset();
        rst = 1'b1;
        sValid = 1'b0;
        sLast = 1'b0;
        mReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expFrames = 0;
        rstPulses = 0;
        gotQ.delete();
    endtask

    // Drives one frame; mode 0 ready=1, 1 toggling ready, 2 random valid/ready,
    // 3 ready=1 but held low for 5 cycles after the last payload transfer.
    // cycles = cycles elapsed before the CRC beat is presented.
    task automatic runFrame(input logic [7:0] q[$], input int mode, input string name,
                            output int cycles);
        int idx = 0;
        int cnt = 0;
        int stallLeft = 5;
        bit done = 0;
        logic prevXfer = 0;
        logic [7:0] prevByte = 8'h00;
        logic prevStall = 0;
        logic [9:0] prevBeat = '0;
        cycles = 0;
        gotQ.delete();
        forever begin
            sValid = (idx < q.size()) && (mode != 2 || $urandom_range(3) != 0);
            sData = sValid ? q[idx] : 8'($urandom);
            sLast = sValid ? (idx == q.size() - 1) : 1'($urandom_range(1));
            case (mode)
                0: mReady = 1'b1;
                1: mReady = (cnt % 2 == 0);
                2: mReady = 1'($urandom_range(1));
                default: begin
                    mReady = !(idx == q.size() && stallLeft > 0);
                    if (!mReady) stallLeft--;
                end
            endcase
            @(negedge clk);
            if (prevXfer) begin
                testsRun++;
                if ({mValid, mLast, mData} !== {2'b10, prevByte}) begin
                    testsFailed++;
                    $display("[TB] FAIL %s latency: got v%b l%b %h, expected v1 l0 %h",
                             name, mValid, mLast, mData, prevByte);
                end
            end
            if (prevStall) begin
                testsRun++;
                if ({mValid, mLast, mData} !== prevBeat) begin
                    testsFailed++;
                    $display("[TB] FAIL %s stall_hold: got %h, expected %h",
                             name, {mValid, mLast, mData}, prevBeat);
                end
            end
            if (mValid && !mReady) begin
                testsRun++;
                if (sReady !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s sready_stall: got %b, expected 0", name, sReady);
                end
            end
            testsRun++;
            if (crcValid !== (sValid && sReady)) begin
                testsFailed++;
                $display("[TB] FAIL %s crc_valid: got %b, expected %b",
                         name, crcValid, sValid && sReady);
            end
            if (crcRst) rstPulses++;
            if (mValid && mReady) gotQ.push_back({mLast, mData});
            prevStall = mValid && !mReady;
            prevBeat = {mValid, mLast, mData};
            prevXfer = sValid && sReady;
            prevByte = sData;
            if (prevXfer) idx++;
            done = (gotQ.size() >= q.size() + 1);
            if (done) cycles = cnt;
            @(posedge clk);
            #1;
            cnt++;
            if (done) break;
            if (cnt > 300) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL %s timeout: got %0d beats, expected %0d",
                         name, gotQ.size(), q.size() + 1);
                break;
            end
        end
        sValid = 1'b0;
        sLast = 1'b0;
        mReady = 1'b1;
    endtask

    task automatic checkFrame(input logic [7:0] q[$], input string name);
        logic [8:0] exp[$];
        foreach (q[i]) exp.push_back({1'b0, q[i]});
        exp.push_back({1'b1, refCrc(q)});
        testsRun++;
        if (gotQ.size() != exp.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s beat_count: got %0d, expected %0d", name, gotQ.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < gotQ.size(); i++) begin
            testsRun++;
            if (gotQ[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL %s beat%0d: got last=%b %h, expected last=%b %h",
                         name, i, gotQ[i][8], gotQ[i][7:0], exp[i][8], exp[i][7:0]);
            end
        end
        expFrames++;
        testsRun++;
        if (framesWide !== 16'(expFrames)) begin
            testsFailed++;
            $display("[TB] FAIL %s frames: got %0d, expected %0d", name, framesWide, 16'(expFrames));
        end
        testsRun++;
        if (framesNarrow !== 2'(expFrames)) begin
            testsFailed++;
            $display("[TB] FAIL %s frames_w2: got %0d, expected %0d", name, framesNarrow, 2'(expFrames));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sValid = 1'b1;
        sData = 8'hA5;
        sLast = 1'b1;
        mReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({mValid, mLast, mData, framesWide, sReady, crcValid, crcRst} !== {2'b00, 8'h00, 16'h0, 3'b001}) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got v%b l%b d%h f%0d rdy%b cv%b cr%b, expected v0 l0 d00 f0 rdy0 cv0 cr1",
                     mValid, mLast, mData, framesWide, sReady, crcValid, crcRst);
        end
        sValid = 1'b0;
        mReady = 1'b1;
        rst = 1'b0;
        #1;
        testsRun++;
        if ({crcRst, sReady} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL reset_first_clear: got cr%b rdy%b, expected cr1 rdy0", crcRst, sReady);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if ({crcRst, sReady} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL reset_then_pass: got cr%b rdy%b, expected cr0 rdy1", crcRst, sReady);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] q[$];
        int cyc;
        applyReset();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        runFrame(q, 0, "single_frame", cyc);
        checkFrame(q, "single_frame");
        testsRun++;
        if (gotQ.size() == 10 && gotQ[9] !== {1'b1, 8'hF4}) begin
            testsFailed++;
            $display("[TB] FAIL single_frame_check_value: got %h, expected 1f4", gotQ[9]);
        end
        testsRun++;
        if (cyc != 11) begin
            testsFailed++;
            $display("[TB] FAIL single_frame_cycles: got %0d, expected 11", cyc);
        end
    endtask

    task automatic test_single_byte_frames();
        logic [7:0] q[$];
        int cyc;
        applyReset();
        q.push_back(8'h01);
        runFrame(q, 0, "byte_frame_01", cyc);
        checkFrame(q, "byte_frame_01");
        testsRun++;
        if (rstPulses != 2) begin
            testsFailed++;
            $display("[TB] FAIL byte_frame_01_clears: got %0d, expected 2", rstPulses);
        end
        q[0] = 8'h00;
        runFrame(q, 0, "byte_frame_00", cyc);
        checkFrame(q, "byte_frame_00");
        testsRun++;
        if (rstPulses != 3) begin
            testsFailed++;
            $display("[TB] FAIL byte_frame_00_clears: got %0d, expected 3", rstPulses);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        int cyc;
        applyReset();
        q.push_back(8'hAA);
        q.push_back(8'h55);
        runFrame(q, 1, "backpressure", cyc);
        checkFrame(q, "backpressure");
    endtask

    task automatic test_crc_stall();
        logic [7:0] q[$];
        int cyc;
        applyReset();
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        runFrame(q, 3, "crc_stall", cyc);
        checkFrame(q, "crc_stall");
        testsRun++;
        if (cyc != 10) begin
            testsFailed++;
            $display("[TB] FAIL crc_stall_cycles: got %0d, expected 10", cyc);
        end
        repeat (4) begin
            @(negedge clk);
            if (mValid && mReady) gotQ.push_back({mLast, mData});
        end
        testsRun++;
        if (gotQ.size() != 4 || framesWide !== 16'(expFrames)) begin
            testsFailed++;
            $display("[TB] FAIL crc_stall_once: got %0d beats frames %0d, expected 4 beats frames %0d",
                     gotQ.size(), framesWide, expFrames);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q[$];
        logic [7:0] one[$];
        int cyc;
        int idx = 0;
        int guard = 0;
        applyReset();
        one.push_back(8'h5A);
        runFrame(one, 0, "pre_reset_frame", cyc);
        checkFrame(one, "pre_reset_frame");
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        while (idx < 4 && guard < 50) begin
            sValid = 1'b1;
            sData = q[idx];
            sLast = 1'b0;
            @(negedge clk);
            if (sReady) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if ({mValid, mLast, mData, framesWide, framesNarrow, sReady, crcValid, crcRst} !==
            {2'b00, 8'h00, 16'h0, 2'b00, 3'b001}) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_outputs: got v%b l%b d%h f%0d fw%0d rdy%b cv%b cr%b, expected v0 l0 d00 f0 fw0 rdy0 cv0 cr1",
                     mValid, mLast, mData, framesWide, framesNarrow, sReady, crcValid, crcRst);
        end
        sValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expFrames = 0;
        rstPulses = 0;
        runFrame(q, 0, "post_reset_frame", cyc);
        checkFrame(q, "post_reset_frame");
    endtask

    task automatic test_random_frames();
        logic [7:0] q[$];
        int cyc;
        for (int f = 0; f < 8; f++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(8, 1); i++) q.push_back(8'($urandom));
            runFrame(q, 2, "random_frame", cyc);
            checkFrame(q, "random_frame");
        end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] q[$];
        logic [1:0] expWrap[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int cyc;
        applyReset();
        q.push_back(8'h00);
        for (int k = 0; k < 5; k++) begin
            q[0] = 8'($urandom);
            runFrame(q, 0, "wrap_frame", cyc);
            checkFrame(q, "wrap_frame");
            testsRun++;
            if (framesNarrow !== expWrap[k]) begin
                testsFailed++;
                $display("[TB] FAIL counter_wrap%0d: got %0d, expected %0d", k, framesNarrow, expWrap[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_single_byte_frames();
        test_backpressure();
        test_crc_stall();
        test_reset_mid_frame();
        test_random_frames();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/crc8_framer.md
# crc8_framer

Frame-level sequencer for the team's byte-wide CRC-8 engine. It accepts a byte stream of frames over a valid/ready interface and clears the engine at each frame start. It feeds every accepted byte to the engine and appends the computed CRC byte as the final beat of each output frame. It sits between a packet source and the serial/link transmitter, and it owns all engine control signals.

## Interface
- `COUNT_WIDTH`, default 16: width of the completed-frame counter.
- `clk_i` input, 1 bit: single clock; all logic on its rising edge.
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `s_data_i` input, 8 bits: input frame byte.
- `s_valid_i` input, 1 bit: input byte valid.
- `s_last_i` input, 1 bit: marks the final payload byte of a frame; qualified by `s_valid_i`.
- `s_ready_o` output, 1 bit: block can accept an input byte this cycle.
- `m_data_o` output, 8 bits: output byte, either payload or the CRC byte.
- `m_valid_o` output, 1 bit: output byte valid.
- `m_last_o` output, 1 bit: marks the CRC byte, which is the last beat of the frame.
- `m_ready_i` input, 1 bit: downstream accepts the output byte.
- `crc_rst_o` output, 1 bit: synchronous clear to the engine.
- `crc_data_o` output, 8 bits: byte presented to the engine. Equals `s_data_i`.
- `crc_valid_o` output, 1 bit: engine update strobe.
- `crc_i` input, 8 bits: engine result.
  - Valid in the cycle after a `crc_valid_o` pulse.
  - Held while `crc_valid_o` is low.
- `frames_o` output, `COUNT_WIDTH` bits: count of CRC bytes loaded. Wraps to 0.

## Operation
- The FSM has three states: CLEAR, PASS and CRC.
- **Input/output transfers**
  - An input transfer is `s_valid_i && s_ready_o`.
  - An output transfer is `m_valid_o && m_ready_i`.
  - `slot_free` = `!m_valid_o || m_ready_i`.
- **Output register.** There is a single output register (`m_data_o`, `m_valid_o`, `m_last_o`). No combinational path runs from `s_*` to `m_*`.
- **CLEAR state**
  - `crc_rst_o` = 1 and `s_ready_o` = 0.
  - Always goes to PASS next cycle.
  - The output register keeps draining normally.
- **PASS state**
  - `s_ready_o` = `slot_free`.
  - On an input transfer:
    - `crc_valid_o` = 1 (combinational). `crc_valid_o` is 0 in all other cases.
    - The output register loads `s_data_i` with `m_last_o` = 0.
    - If `s_last_i` = 1, go to CRC.
  - If `slot_free` holds and there is no input transfer, `m_valid_o` clears.
- **CRC state**
  - `s_ready_o` = 0.
  - When `slot_free`: load `crc_i` into `m_data_o` with `m_valid_o` = 1 and `m_last_o` = 1, increment `frames_o`, and go to CLEAR.
  - Otherwise stay in CRC. The engine holds its result, so no capture register is needed.
- **Clear timing.** CLEAR does not wait for the CRC byte to drain. The engine clear does not disturb the output register.
- **Engine settings.** The polynomial and initial value are engine settings. This block is transparent to them. The team default is 0x07 with init 0x00.

## Timing
- **Reset (async assert)**
  - State = CLEAR.
  - `m_valid_o` = 0, `m_last_o` = 0, `m_data_o` = 0x00, `frames_o` = 0.
  - `s_ready_o` = 0, `crc_valid_o` = 0.
  - `crc_rst_o` = 1 while in CLEAR.
  - The first cycle after deassertion is a CLEAR cycle.
- **Latency:** an input byte appears on `m_data_o` 1 cycle after its input transfer.
- **Throughput:** an N-byte frame takes N+2 cycles, made of 1 CLEAR cycle, N PASS cycles and 1 CRC cycle. It produces N+1 output beats.
- **CRC cycle timing:** the CRC cycle is exactly the cycle after the last-byte transfer. `crc_i` is valid in that cycle.
- **Backpressure**
  - `m_ready_i` low holds all `m_*` outputs stable.
  - `s_ready_o` drops in the same cycle.
  - No byte is ever lost or duplicated.
- **`s_last_i` outside PASS** has no effect, because no transfer occurs.
- **Reset mid-frame** discards the partial frame and any pending CRC byte. The next frame's CRC is computed from a cleared engine.
- **`frames_o` wrap:** all-ones + 1 = 0.

## Test plan
- **Single frame:** "123456789" (0x31..0x39), last on 0x39, `m_ready_i` = 1.
  - Output is 0x31..0x39 then 0xF4 with `m_last_o` = 1.
  - The whole frame completes in 11 cycles.
  - `frames_o` = 1.
- **Single-byte frames:** 0x01 then 0x00, back to back.
  - Outputs are 0x01, 0x07(last), then 0x00, 0x00(last).
  - `crc_rst_o` pulses once before each frame.
- **Backpressure:** frame 0xAA, 0x55; `m_ready_i` toggles 1/0 every cycle.
  - The output sequence is unchanged, ending 0xAA, 0x55 then the CRC byte for {0xAA,0x55} as computed by the reference model, with `m_last_o` = 1.
  - `m_*` are stable while stalled.
  - `s_ready_o` = 0 whenever a stall blocks the slot.
- **CRC stall:** hold `m_ready_i` = 0 for 5 cycles after the last payload byte.
  - The FSM stays in CRC.
  - The CRC byte is emitted once after release.
  - `frames_o` increments once.
- **Reset mid-frame:** assert `rst_i` asynchronously after 4 bytes of "123456789", then send the full frame.
  - All outputs go to their reset values immediately.
  - The next frame ends with 0xF4.
- **Counter wrap:** with `COUNT_WIDTH` = 2, send 5 one-byte frames. `frames_o` reads 1, 2, 3, 0, 1.
